grf_scoreboard: RTL and testbench

Parametrised general register file with per-register pending-write tracking, for the pipelined CPU datapath. It provides `NR` combinational read ports and one write-back port with same-cycle write-to-read bypass. It also keeps a saturating outstanding-write counter per register, so the hazard unit can stall a read until every issued producer has written back.

---
 rtl/grf_scoreboard.sv | 110 +++++++++++
 tb/tb_grf_scoreboard.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: general register file with per-register pending-write counters and write-back bypass.
// Latency: reads are combinational (0 cycles); writes and counter updates land at the rising clk edge.
// Backpressure: issue_ready drops when a register already holds 2^CW-1 outstanding writes and no
//   same-cycle write-back frees a slot; a refused issue changes no state and must be held by the issuer.
// Ports: clk/reset (async active-low); rd_addr/rd_data/rd_busy (NR read ports); issue_en/issue_addr/
//   issue_ready (claim a pending write); wb_en/wb_addr/wb_data/wb_pc (write-back); flush (clear counters).
// Optional feature: define GRF_TRACE_EN to print one trace line per write-back to a non-zero register.
module grf_scoreboard #(
   parameter int WIDTH = 32,
   parameter int AW    = 5,
   parameter int NR    = 2,
   parameter int CW    = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NR*AW-1:0]    rd_addr,
   output logic [NR*WIDTH-1:0] rd_data,
   output logic [NR-1:0]       rd_busy,
   input  logic                issue_en,
   input  logic [AW-1:0]       issue_addr,
   output logic                issue_ready,
   input  logic                wb_en,
   input  logic [AW-1:0]       wb_addr,
   input  logic [WIDTH-1:0]    wb_data,
   input  logic [31:0]         wb_pc,
   input  logic                flush
);

   localparam int            DEPTH   = 1 << AW;
   localparam logic [CW-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [CW-1:0]    cnt_q  [DEPTH];
   logic [CW-1:0]    cnt_d  [DEPTH];

   // A write-back only counts outside reset and never targets register 0; this
   // keeps the bypass path from leaking wb_data while reset holds everything at 0.
   logic wb_live;
   logic wb_frees;
   logic issue_acc;

   assign wb_live = reset && wb_en && (wb_addr != '0);

   // Read ports: bypass a matching write-back, and discount it from the pending
   // count so the final producer clears busy in its own write-back cycle.
   for (genvar i = 0; i < NR; i++) begin : g_rd
      logic [AW-1:0] a;
      logic          hit;
      assign a   = rd_addr[i*AW +: AW];
      assign hit = wb_live && (wb_addr == a);
      assign rd_data[i*WIDTH +: WIDTH] = (a == '0) ? '0 : (hit ? wb_data : regs_q[a]);
      assign rd_busy[i] = hit ? (cnt_q[a] > CW'(1)) : (cnt_q[a] != '0);
   end

   // A saturated register can still take an issue if a write-back retires one
   // of its pending writes in the same cycle (net count unchanged).
   assign wb_frees    = wb_live && (wb_addr == issue_addr) && (cnt_q[issue_addr] != '0);
   assign issue_ready = (issue_addr == '0) || (cnt_q[issue_addr] != CNT_MAX) || wb_frees;
   assign issue_acc   = issue_en && issue_ready && (issue_addr != '0);

   always_comb begin
      for (int r = 0; r < DEPTH; r++) begin
         regs_d[r] = regs_q[r];
         cnt_d[r]  = cnt_q[r];
      end
      // Data still lands during a flush; only the bookkeeping is discarded.
      if (wb_live) begin
         regs_d[wb_addr] = wb_data;
      end
      for (int r = 1; r < DEPTH; r++) begin
         if (flush) begin
            cnt_d[r] = '0;
         end else if ((issue_acc && (issue_addr == AW'(r))) &&
                      !(wb_live && (wb_addr == AW'(r)) && (cnt_q[r] != '0))) begin
            cnt_d[r] = cnt_q[r] + CW'(1);
         end else if (!(issue_acc && (issue_addr == AW'(r))) &&
                      (wb_live && (wb_addr == AW'(r)) && (cnt_q[r] != '0))) begin
            cnt_d[r] = cnt_q[r] - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            regs_q[r] <= regs_d[r];
            cnt_q[r]  <= cnt_d[r];
         end
      end
   end

`ifdef GRF_TRACE_EN
   always @(posedge clk) begin
      if (reset && wb_en && (wb_addr != '0)) begin
         $display("@%h: $%d <= %h", wb_pc, wb_addr, wb_data);
      end
   end
`else
   // wb_pc only feeds the trace; fold it away when tracing is compiled out.
   logic unused_wb_pc;
   assign unused_wb_pc = ^wb_pc;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// tb_grf_scoreboard: directed plus randomized stimulus for grf_scoreboard with a queue-based scoreboard.
// Latency: each stimulus cycle pushes one expected record; the monitor pops it half a cycle later.
// Backpressure: none; the reference model decides issue acceptance from its own pending counts.
module tb_grf_scoreboard;
   localparam int WIDTH = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int CW    = 2;
   localparam int DEPTH = 32;
   localparam int CMAX  = 3;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic [NR*AW-1:0]    rd_addr = '0;
   logic [NR*WIDTH-1:0] rd_data;
   logic [NR-1:0]       rd_busy;
   logic                issue_en = 1'b0;
   logic [AW-1:0]       issue_addr = '0;
   logic                issue_ready;
   logic                wb_en = 1'b0;
   logic [AW-1:0]       wb_addr = '0;
   logic [WIDTH-1:0]    wb_data = '0;
   logic [31:0]         wb_pc = '0;
   logic                flush = 1'b0;

   grf_scoreboard #(.WIDTH(WIDTH), .AW(AW), .NR(NR), .CW(CW)) dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .issue_en(issue_en), .issue_addr(issue_addr), .issue_ready(issue_ready),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc), .flush(flush)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NR*WIDTH-1:0] data;
      logic [NR-1:0]       busy;
      logic                ready;
      int                  cyc;
   } exp_t;

   exp_t exp_q[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   cyc       = 0;

   // Reference model: plain register contents and outstanding-write counts.
   logic [31:0] m_regs [DEPTH];
   int          m_cnt  [DEPTH];

   initial begin
      for (int r = 0; r < DEPTH; r++) begin
         m_regs[r] = '0;
         m_cnt[r]  = 0;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req, input int c);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, req);
   endtask

   // Monitor: DUT outputs are stable at the falling edge for the stimulus set just after the rising edge.
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("rd_data0",    64'(rd_data[WIDTH-1:0]),       64'(mon_e.data[WIDTH-1:0]),       mon_e.cyc);
            check("rd_data1",    64'(rd_data[2*WIDTH-1:WIDTH]), 64'(mon_e.data[2*WIDTH-1:WIDTH]), mon_e.cyc);
            check("rd_busy",     64'(rd_busy),                  64'(mon_e.busy),                  mon_e.cyc);
            check("issue_ready", 64'(issue_ready),              64'(mon_e.ready),                 mon_e.cyc);
         end
      end
   end

   task automatic step(input logic rst, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                       input logic ie, input logic [AW-1:0] ia,
                       input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                       input logic fl);
      exp_t e;
      int   a;
      bit   hit, acc, dec;
      @(posedge clk);
      #1;
      reset      = rst;
      rd_addr    = {ra1, ra0};
      issue_en   = ie;
      issue_addr = ia;
      wb_en      = we;
      wb_addr    = wa;
      wb_data    = wd;
      wb_pc      = $urandom;
      flush      = fl;
      cyc++;
      if (!rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            m_regs[r] = '0;
            m_cnt[r]  = 0;
         end
      end
      e.data = '0;
      e.busy = '0;
      for (int i = 0; i < NR; i++) begin
         a   = (i == 0) ? int'(ra0) : int'(ra1);
         hit = rst && we && (int'(wa) == a) && (a != 0);
         e.data[i*WIDTH +: WIDTH] = (a == 0) ? 32'h0 : (hit ? wd : m_regs[a]);
         e.busy[i] = (a != 0) && ((m_cnt[a] - (hit ? 1 : 0)) > 0);
      end
      e.ready = (ia == 0) || (m_cnt[ia] < CMAX) || (rst && we && (wa == ia) && (m_cnt[ia] > 0));
      e.cyc   = cyc;
      exp_q.push_back(e);
      if (rst) begin
         acc = ie && e.ready && (ia != 0);
         dec = we && (wa != 0) && (m_cnt[wa] > 0);
         if (fl) begin
            for (int r = 0; r < DEPTH; r++) m_cnt[r] = 0;
         end else begin
            if (acc) m_cnt[ia] = m_cnt[ia] + 1;
            if (dec) m_cnt[wa] = m_cnt[wa] - 1;
         end
         if (we && (wa != 0)) m_regs[wa] = wd;
      end
   endtask

   initial begin
      // Reset, then write $5 and assert reset mid-run.
      step(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
      step(1, 5, 0, 0, 0, 1, 5, 32'h1234, 0);
      step(1, 5, 5, 1, 5, 0, 0, 32'h0, 0);
      step(0, 5, 5, 1, 5, 1, 5, 32'h9999, 0);
      step(1, 5, 0, 0, 0, 0, 0, 32'h0, 0);
      // Write then read with bypass, then from storage.
      step(1, 3, 3, 0, 0, 1, 3, 32'hDEADBEEF, 0);
      step(1, 3, 0, 0, 0, 0, 0, 32'h0, 0);
      // Register 0.
      step(1, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0);
      step(1, 0, 0, 1, 0, 0, 0, 32'h0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
      // Pending lifecycle on $7.
      step(1, 7, 7, 1, 7, 0, 0, 32'h0, 0);
      step(1, 7, 7, 1, 7, 0, 0, 32'h0, 0);
      step(1, 7, 0, 0, 0, 0, 0, 32'h0, 0);
      step(1, 7, 0, 0, 0, 1, 7, 32'h11, 0);
      step(1, 7, 0, 0, 0, 1, 7, 32'h22, 0);
      step(1, 7, 7, 0, 0, 0, 0, 32'h0, 0);
      // Saturation on $9.
      step(1, 9, 0, 1, 9, 0, 0, 32'h0, 0);
      step(1, 9, 0, 1, 9, 0, 0, 32'h0, 0);
      step(1, 9, 0, 1, 9, 0, 0, 32'h0, 0);
      step(1, 9, 0, 1, 9, 0, 0, 32'h0, 0);
      step(1, 9, 0, 1, 9, 1, 9, 32'hAB, 0);
      step(1, 9, 9, 0, 9, 0, 0, 32'h0, 0);
      // Flush with pending on $4 and $6.
      step(1, 4, 6, 1, 4, 0, 0, 32'h0, 0);
      step(1, 4, 6, 1, 6, 0, 0, 32'h0, 0);
      step(1, 4, 6, 1, 8, 1, 4, 32'h55, 1);
      step(1, 4, 6, 0, 0, 0, 0, 32'h0, 0);
      step(1, 8, 9, 0, 0, 0, 0, 32'h0, 0);
      // Randomized traffic over a small address range to provoke hazards.
      for (int n = 0; n < 600; n++) begin
         step(logic'($urandom_range(0, 99) != 0),
              AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
              logic'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
              logic'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
              logic'($urandom_range(0, 39) == 0));
      end
      repeat (3) @(negedge clk);
      total_cnt++;
      if (exp_q.size() == 0) pass_cnt++;
      else $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
